// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one 3-bit equality comparator among N_REQ requesters.
// Each grant takes three cycles: IDLE (capture) -> CMP (compare) -> ACK (one-cycle pulse).
module cmp_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   a_bus,
    input  logic [3*N_REQ-1:0]   b_bus,
    output logic [N_REQ-1:0]     ack,
    output logic                 eq,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [CNT_W-1:0]     match_cnt
);

    typedef enum logic [1:0] {StIdle, StCmp, StAck} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_a_q, op_a_d;
    logic [2:0]         op_b_q, op_b_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               eq_q, eq_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

    logic               found;
    logic [2:0]         win_id, win_a, win_b;
    logic               cmp;

    assign cmp = &(op_a_q ~^ op_b_q);

    // Rotating priority: requesters at or above rr_ptr first, then wrap to those below it.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        win_a  = '0;
        win_b  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (3'(i) >= rr_ptr_q)) begin
                found  = 1'b1;
                win_id = 3'(i);
                win_a  = a_bus[3*i +: 3];
                win_b  = b_bus[3*i +: 3];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (3'(i) < rr_ptr_q)) begin
                found  = 1'b1;
                win_id = 3'(i);
                win_a  = a_bus[3*i +: 3];
                win_b  = b_bus[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = '0;
        eq_d        = eq_q;
        busy_d      = busy_q;
        match_cnt_d = match_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    op_a_d     = win_a;
                    op_b_d     = win_b;
                    grant_id_d = win_id;
                    busy_d     = 1'b1;
                    state_d    = StCmp;
                end
            end
            StCmp: begin
                eq_d = cmp;
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    ack_d[i] = (grant_id_q == 3'(i));
                end
                if (cmp && (match_cnt_q != '1)) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
                state_d = StAck;
            end
            StAck: begin
                busy_d   = 1'b0;
                rr_ptr_d = (grant_id_q == 3'(N_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_a_q      <= '0;
            op_b_q      <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            ack_q       <= '0;
            eq_q        <= 1'b0;
            busy_q      <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            eq_q        <= eq_d;
            busy_q      <= busy_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign ack       = ack_q;
    assign eq        = eq_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Scoreboard bench for cmp_share_arbiter: stimulus pushes expected acks, monitors pop and compare.
// A second instance with a 2-bit counter covers saturation.
module tb_cmp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, ack, req_s, ack_s;
    logic [11:0] a_bus, b_bus, a_bus_s, b_bus_s;
    logic        eq, busy, eq_s, busy_s;
    logic [2:0]  grant_id, grant_id_s;
    logic [7:0]  match_cnt;
    logic [1:0]  match_cnt_s;

    always #5 clk = ~clk;

    cmp_share_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .ack(ack), .eq(eq), .busy(busy), .grant_id(grant_id), .match_cnt(match_cnt)
    );

    cmp_share_arbiter #(.N_REQ(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req(req_s), .a_bus(a_bus_s), .b_bus(b_bus_s),
        .ack(ack_s), .eq(eq_s), .busy(busy_s), .grant_id(grant_id_s),
        .match_cnt(match_cnt_s)
    );

    typedef struct {
        logic [3:0] ack;
        logic [2:0] gid;
        logic       eq;
        logic [7:0] cnt;
    } exp_t;

    exp_t       q_main[$];
    exp_t       q_sat[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] exp_cnt    = 8'd0;
    logic [1:0] exp_cnt_s  = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input int id, input logic e, input int cnt);
        exp_t r;
        r.ack = 4'(1 << id);
        r.gid = 3'(id);
        r.eq  = e;
        r.cnt = 8'(cnt);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (ack !== 4'b0) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = q_main.pop_front();
                check("main_ack", 32'(ack), 32'(e.ack));
                check("main_gid", 32'(grant_id), 32'(e.gid));
                check("main_eq", 32'(eq), 32'(e.eq));
                check("main_cnt", 32'(match_cnt), 32'(e.cnt));
                check("main_busy_in_ack", 32'(busy), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ack_s !== 4'b0) begin
            if (q_sat.size() == 0) begin
                check("sat_unexpected_ack", 32'(ack_s), 32'd0);
            end else begin
                e = q_sat.pop_front();
                check("sat_ack", 32'(ack_s), 32'(e.ack));
                check("sat_eq", 32'(eq_s), 32'(e.eq));
                check("sat_cnt", 32'(match_cnt_s), 32'(e.cnt));
            end
        end
    end

    // Waits (bounded) for ack[id] on the chosen instance; n = negedges elapsed.
    task automatic wait_ack(input bit sat, input int id, input string name, output int n);
        bit seen = 1'b0;
        n = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            seen = sat ? ack_s[id] : ack[id];
        end
        check(name, 32'(seen), 32'd1);
    endtask

    // Called one step after a clock edge with the DUT idle.
    task automatic do_txn(input bit sat, input int id, input logic [2:0] a, input logic [2:0] b);
        logic m;
        int   n;
        m = (a == b);
        if (sat) begin
            if (m && exp_cnt_s != 2'b11) exp_cnt_s++;
            q_sat.push_back(mk(id, m, int'(exp_cnt_s)));
            a_bus_s[3*id +: 3] = a;
            b_bus_s[3*id +: 3] = b;
            req_s[id] = 1'b1;
        end else begin
            if (m && exp_cnt != 8'hFF) exp_cnt++;
            q_main.push_back(mk(id, m, int'(exp_cnt)));
            a_bus[3*id +: 3] = a;
            b_bus[3*id +: 3] = b;
            req[id] = 1'b1;
        end
        wait_ack(sat, id, sat ? "sat_ack_seen" : "ack_seen", n);
        check("ack_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        if (sat) req_s[id] = 1'b0;
        else req[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        int t[5];
        int n_ack;
        int sat_tab[5];
        sat_tab = '{1, 2, 3, 3, 3};

        rst = 1'b1;
        req = '0;  a_bus = '0;  b_bus = '0;
        req_s = '0; a_bus_s = '0; b_bus_s = '0;
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eq", 32'(eq), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_txn(1'b0, 0, 3'b101, 3'b101);
        do_txn(1'b0, 0, 3'b101, 3'b100);

        // Reset while in CMP aborts the transaction immediately.
        a_bus[2:0] = 3'd6;
        b_bus[2:0] = 3'd6;
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        check("busy_in_cmp", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cnt", 32'(match_cnt), 32'd0);
        req = '0;
        exp_cnt = 8'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        n_ack = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack != 4'b0) n_ack++;
        end
        check("no_ack_after_reset", 32'(n_ack), 32'd0);
        @(posedge clk);
        #1;

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                do_txn(1'b0, 2, 3'(a), 3'(b));
            end
        end
        check("exhaustive_cnt", 32'(match_cnt), 32'd8);

        do_txn(1'b0, 3, 3'd7, 3'd7);

        // All four requesting continuously; rr_ptr is 0 after requester 3.
        a_bus = {3'd0, 3'd5, 3'd2, 3'd1};
        b_bus = {3'd7, 3'd5, 3'd3, 3'd1};
        q_main.push_back(mk(0, 1'b1, 10));
        q_main.push_back(mk(1, 1'b0, 10));
        q_main.push_back(mk(2, 1'b1, 11));
        q_main.push_back(mk(3, 1'b0, 11));
        q_main.push_back(mk(0, 1'b1, 12));
        exp_cnt = 8'd12;
        req = 4'b1111;
        k = 0;
        n = 0;
        while (k < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (ack != 4'b0) begin
                t[k] = n;
                k++;
            end
        end
        check("rr_ack_count", 32'(k), 32'd5);
        check("rr_first_latency", 32'(t[0]), 32'd3);
        for (int i = 1; i < 5; i++) begin
            check("rr_spacing", 32'(t[i] - t[i-1]), 32'd3);
        end
        @(posedge clk);
        #1 req = '0;

        // Operand change after grant must not affect the in-flight compare.
        a_bus[5:3] = 3'd3;
        b_bus[5:3] = 3'd3;
        q_main.push_back(mk(1, 1'b1, 13));
        req[1] = 1'b1;
        @(posedge clk);
        #1 a_bus[5:3] = 3'd4;
        wait_ack(1'b0, 1, "stab_ack_seen", n);
        @(posedge clk);
        #1 req[1] = 1'b0;

        // req3 raised during ACK of 0 while 0 re-requests: 3 goes first, then 0.
        a_bus[2:0]  = 3'd2;
        b_bus[2:0]  = 3'd2;
        a_bus[11:9] = 3'd1;
        b_bus[11:9] = 3'd6;
        q_main.push_back(mk(0, 1'b1, 14));
        q_main.push_back(mk(3, 1'b0, 14));
        q_main.push_back(mk(0, 1'b1, 15));
        exp_cnt = 8'd15;
        req[0] = 1'b1;
        wait_ack(1'b0, 0, "late_ack0_seen", n);
        check("late_ack0_latency", 32'(n), 32'd3);
        req[3] = 1'b1;
        wait_ack(1'b0, 3, "late_ack3_seen", n);
        check("late_ack3_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1 req[3] = 1'b0;
        wait_ack(1'b0, 0, "late_reack0_seen", n);
        check("late_reack0_latency", 32'(n), 32'd3);
        @(posedge clk);
        #1 req[0] = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_txn(1'b1, 0, 3'd3, 3'd3);
            check("sat_cnt_after", 32'(match_cnt_s), 32'(sat_tab[i]));
        end

        repeat (4) @(negedge clk);
        check("main_queue_drained", 32'(q_main.size()), 32'd0);
        check("sat_queue_drained", 32'(q_sat.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cmp_share_arbiter.md
Name: cmp_share_arbiter

Overview:
- Time-shares one 3-bit equality comparator among N_REQ requesters.
- Each requester presents an operand pair (A, B) and raises req.
- A round-robin FSM grants one requester at a time, latches its operands into the shared comparator and returns the equality result with a one-cycle ack pulse.
- Also keeps a saturating count of matches for status readout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request; held high until own ack
- a_bus  in  3*N_REQ  operand A; requester i uses bits [3i+2:3i]
- b_bus  in  3*N_REQ  operand B; requester i uses bits [3i+2:3i]
- ack  out  N_REQ  one-hot, one-cycle pulse to the serviced requester
- eq  out  1  comparison result (1 = A equals B); valid while ack != 0, held otherwise
- busy  out  1  high in CMP and ACK states
- grant_id  out  3  index of current/last granted requester
- match_cnt  out  CNT_W  number of eq=1 results since reset, saturating at all-ones

Behaviour:
- Reset (async, rst=1): state=IDLE, ack=0, eq=0, busy=0, grant_id=0, rr_ptr=0, match_cnt=0, op_a=op_b=0. All outputs clear immediately, not at the next edge.
- Datapath:
  - Registered operands op_a/op_b feed one 3-bit equality comparator.
  - cmp = AND over bits of XNOR(op_a[k], op_b[k]).
  - The comparator is purely combinational from registers.
- FSM states IDLE, CMP, ACK:
  - IDLE: if req==0, stay. Otherwise select winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, …, wrapping mod N_REQ. On that edge: op_a/op_b <= winner's operands, grant_id <= winner, busy <= 1, state <= CMP.
  - CMP: on the edge, eq <= cmp, ack <= one-hot(grant_id), state <= ACK. If cmp=1 and match_cnt != all-ones, match_cnt += 1.
  - ACK: ack high this cycle only. Requests are not sampled. On the edge: ack <= 0, busy <= 0, rr_ptr <= (grant_id+1) mod N_REQ, state <= IDLE.
- Latency: req sampled at edge t → ack high in cycle t+2 → earliest next grant at edge t+3. Throughput is one comparison per 3 cycles.
- Handshake:
  - Requester keeps req and operands stable until it sees ack.
  - Requester deasserts req on the edge ending the ack cycle (or presents a new request).
  - Operands are captured only at grant; later changes do not affect the in-flight result.
  - A req that drops before being granted is simply not serviced.
- Fairness: after granting i, requester i has lowest priority next arbitration. With all N_REQ requesting continuously, each is granted exactly once per N_REQ transactions.
- Simultaneous events:
  - New req arriving in CMP/ACK waits for IDLE.
  - A req raised by the just-acked requester in the ack cycle is eligible next IDLE, but only after all other pending requesters per rr_ptr.
- Wrap-around: rr_ptr wraps N_REQ-1 → 0.
- Saturation: match_cnt holds at all-ones.
- Reset mid-operation: transaction aborted, no ack issued, state returns to IDLE. Requesters must re-request.
- eq and grant_id hold their last values after ack until the next CMP edge.

Test Plan:
- Reset check: assert rst mid-CMP with req=0001 → ack=0, busy=0, match_cnt=0, state IDLE immediately; no ack after release.
- Single requester: req=0001, A0=3'b101, B0=3'b101 → ack=0001 two cycles after sampling edge, eq=1, match_cnt=1. Repeat with B0=3'b100 → eq=0, match_cnt stays 1.
- Exhaustive compare: requester 2 iterates all 64 (A, B) pairs → eq=1 exactly for the 8 pairs with A==B, match_cnt=8 at end.
- Round-robin: req=1111 held continuously, each requester re-requesting after its ack → ack order 0001, 0010, 0100, 1000, 0001; ack pulses spaced 3 cycles apart.
- Operand stability: change A1 after grant, in CMP → eq reflects captured value. Raise req3 during ACK of requester 0 → req3 granted at next IDLE.
- Saturation: CNT_W=2, 5 matching transactions → match_cnt=3 after 3rd and remains 3.
